// File: rtl/rgb_timing_gen.sv
// Video timing generator for 640x480@60 in the pixel-clock domain.
// Qualifies PLL lock, then free-runs h/v counters and emits registered sync, de, coordinates and strobes.
module rgb_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int LOCK_SETTLE = 16,
  parameter int COORD_W     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock,
  output logic               running,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_ACT      = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] H_SYNC_BEG = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] H_SYNC_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_ACT      = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] V_SYNC_BEG = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] V_SYNC_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);

  // The settle counter only needs to reach LOCK_SETTLE-1: the edge that sees it there enters RUN.
  localparam int                  SETTLE_W    = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(LOCK_SETTLE - 1);

  typedef enum logic {WAIT_LOCK, RUN} state_t;

  typedef struct packed {
    logic               running;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               line_start;
    logic               frame_start;
  } vid_t;

  function automatic vid_t idle_vid();
    vid_t o;
    o       = '0;
    o.hsync = ~HSYNC_POL;
    o.vsync = ~VSYNC_POL;
    return o;
  endfunction

  function automatic vid_t decode(input logic [COORD_W-1:0] h, input logic [COORD_W-1:0] v);
    vid_t o;
    o.running     = 1'b1;
    o.de          = (h < H_ACT) && (v < V_ACT);
    o.hsync       = (h >= H_SYNC_BEG && h < H_SYNC_END) ? HSYNC_POL : ~HSYNC_POL;
    o.vsync       = (v >= V_SYNC_BEG && v < V_SYNC_END) ? VSYNC_POL : ~VSYNC_POL;
    o.x           = o.de ? h : '0;
    o.y           = o.de ? v : '0;
    o.line_start  = (h == '0) && (v < V_ACT);
    o.frame_start = (h == '0) && (v == '0);
    return o;
  endfunction

  logic [1:0]          sync_q;
  logic                lock_s;
  state_t              state_q, state_d;
  logic [COORD_W-1:0]  h_q, h_d, v_q, v_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  vid_t                vid_q, vid_d;

  assign lock_s = sync_q[1];

  // Outputs are registered from the decode of the *next* counter values, so the
  // registered outputs always line up with the counters they describe.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    h_d      = '0;
    v_d      = '0;
    settle_d = '0;
    vid_d    = idle_vid();
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          if (settle_q == SETTLE_LAST) begin
            state_d = RUN;
            vid_d   = decode('0, '0);
          end else begin
            settle_d = settle_q + SETTLE_W'(1);
          end
        end
      end
      RUN: begin
        if (lock_s) begin
          if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + COORD_W'(1);
          end else begin
            h_d = h_q + COORD_W'(1);
            v_d = v_q;
          end
          vid_d = decode(h_d, v_d);
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      sync_q   <= 2'b00;
      state_q  <= WAIT_LOCK;
      h_q      <= '0;
      v_q      <= '0;
      settle_q <= '0;
      vid_q    <= idle_vid();
    end else begin
      sync_q   <= {sync_q[0], pll_lock};
      state_q  <= state_d;
      h_q      <= h_d;
      v_q      <= v_d;
      settle_q <= settle_d;
      vid_q    <= vid_d;
    end
  end

  assign running     = vid_q.running;
  assign hsync       = vid_q.hsync;
  assign vsync       = vid_q.vsync;
  assign de          = vid_q.de;
  assign x           = vid_q.x;
  assign y           = vid_q.y;
  assign line_start  = vid_q.line_start;
  assign frame_start = vid_q.frame_start;

endmodule

// File: tb/tb_rgb_timing_gen.sv
// Directed bench for rgb_timing_gen: full 640x480 instance for lock/line timing,
// a shrunken active-high-sync instance (15x11 frame, LOCK_SETTLE=1) for frame-level behaviour.
module tb_rgb_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, lock_a, rst_b, lock_b;
  logic       running_a, hsync_a, vsync_a, de_a, line_start_a, frame_start_a;
  logic [9:0] x_a, y_a;
  logic       running_b, hsync_b, vsync_b, de_b, line_start_b, frame_start_b;
  logic [3:0] x_b, y_b;

  int n_cmp = 0;
  int n_bad = 0;

  rgb_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .pll_lock(lock_a), .running(running_a),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .x(x_a), .y(y_a),
    .line_start(line_start_a), .frame_start(frame_start_a)
  );

  // Small frame: H_TOTAL=15 (hsync h=10..12), V_TOTAL=11 (vsync v=8..9), 8x6 active.
  rgb_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .LOCK_SETTLE(1), .COORD_W(4)
  ) dut_b (
    .clk(clk), .rst(rst_b), .pll_lock(lock_b), .running(running_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .x(x_b), .y(y_b),
    .line_start(line_start_b), .frame_start(frame_start_b)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; lock_a = 1'b0; lock_b = 1'b0;
    tick(4);
    n_cmp++;
    if ({running_a, hsync_a, vsync_a, de_a, line_start_a, frame_start_a, x_a, y_a} !== {6'b011000, 20'd0}) begin
      n_bad++;
      $display("FAIL reset_a: got %b/%0d/%0d want 011000/0/0",
               {running_a, hsync_a, vsync_a, de_a, line_start_a, frame_start_a}, x_a, y_a);
    end
    n_cmp++;
    if ({running_b, hsync_b, vsync_b, de_b, line_start_b, frame_start_b, x_b, y_b} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_b_idle_low: got %b/%0d/%0d want 000000/0/0",
               {running_b, hsync_b, vsync_b, de_b, line_start_b, frame_start_b}, x_b, y_b);
    end
    rst_a = 1'b0; rst_b = 1'b0;
  endtask

  task automatic test_power_up();
    for (int i = 0; i < 100; i++) begin
      tick(1);
      n_cmp++;
      if ({running_a, hsync_a, vsync_a, de_a} !== 4'b0110) begin
        n_bad++;
        $display("FAIL idle_no_lock cycle %0d: got %b want 0110", i, {running_a, hsync_a, vsync_a, de_a});
      end
    end
    lock_a = 1'b1;
    tick(1);
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      n_cmp++;
      if (running_a !== 1'b0) begin
        n_bad++;
        $display("FAIL early_run edge %0d: got %b want 0", i, running_a);
      end
    end
    tick(1);
    n_cmp++;
    if ({running_a, frame_start_a, line_start_a, de_a, hsync_a, vsync_a, x_a, y_a} !== {6'b111111, 20'd0}) begin
      n_bad++;
      $display("FAIL first_run_cycle: got %b/%0d/%0d want 111111/0/0",
               {running_a, frame_start_a, line_start_a, de_a, hsync_a, vsync_a}, x_a, y_a);
    end
  endtask

  task automatic test_line_timing();
    int de_cnt = 0, x_err = 0, y_err = 0, hs_cnt = 0, hs_first = -1, hs_last = -1, ls_cnt = 0;
    for (int h = 0; h < 800; h++) begin
      if (de_a !== (h < 640)) x_err++;
      if (de_a === 1'b1) begin
        de_cnt++;
        if (x_a !== 10'(h)) x_err++;
      end else if (x_a !== 10'd0) x_err++;
      if (y_a !== 10'd0) y_err++;
      if (hsync_a === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = h;
        hs_last = h;
      end
      if (line_start_a === 1'b1) ls_cnt++;
      tick(1);
    end
    n_cmp++;
    if (de_cnt !== 640) begin n_bad++; $display("FAIL de_per_line: got %0d want 640", de_cnt); end
    n_cmp++;
    if (x_err !== 0) begin n_bad++; $display("FAIL x_sequence: got %0d errors want 0", x_err); end
    n_cmp++;
    if (y_err !== 0) begin n_bad++; $display("FAIL y_line0: got %0d errors want 0", y_err); end
    n_cmp++;
    if (hs_cnt !== 96) begin n_bad++; $display("FAIL hsync_width: got %0d want 96", hs_cnt); end
    n_cmp++;
    if (hs_first !== 656 || hs_last !== 751) begin
      n_bad++;
      $display("FAIL hsync_window: got %0d..%0d want 656..751", hs_first, hs_last);
    end
    n_cmp++;
    if (ls_cnt !== 1) begin n_bad++; $display("FAIL line_start_count: got %0d want 1", ls_cnt); end
    n_cmp++;
    if ({line_start_a, frame_start_a, de_a, x_a, y_a} !== {3'b101, 10'd0, 10'd1}) begin
      n_bad++;
      $display("FAIL second_line_start: got %b/%0d/%0d want 101/0/1",
               {line_start_a, frame_start_a, de_a}, x_a, y_a);
    end
  endtask

  task automatic test_lock_glitch();
    lock_a = 1'b0;
    tick(3);
    n_cmp++;
    if ({running_a, hsync_a, vsync_a, de_a} !== 4'b0110) begin
      n_bad++;
      $display("FAIL lock_drop_a: got %b want 0110", {running_a, hsync_a, vsync_a, de_a});
    end
    lock_a = 1'b1;
    tick(12);
    n_cmp++;
    if (running_a !== 1'b0) begin n_bad++; $display("FAIL qualifying: got %b want 0", running_a); end
    lock_a = 1'b0;
    tick(1);
    lock_a = 1'b1;
    tick(1);
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      n_cmp++;
      if (running_a !== 1'b0) begin
        n_bad++;
        $display("FAIL glitch_early_run edge %0d: got %b want 0", i, running_a);
      end
    end
    tick(1);
    n_cmp++;
    if ({running_a, frame_start_a} !== 2'b11) begin
      n_bad++;
      $display("FAIL glitch_restart: got %b want 11", {running_a, frame_start_a});
    end
  endtask

  task automatic test_frame_timing();
    int de_cnt = 0, x_err = 0, vs_cnt = 0, vs_first = -1, vs_last = -1;
    int hs_cnt = 0, hs_bad = 0, ls_cnt = 0, ls_late = 0, fs_extra = 0;
    lock_b = 1'b1;
    tick(2);
    n_cmp++;
    if (running_b !== 1'b0) begin n_bad++; $display("FAIL b_early_run: got %b want 0", running_b); end
    tick(1);
    n_cmp++;
    if ({running_b, frame_start_b, line_start_b, de_b, hsync_b, vsync_b, x_b, y_b} !== {6'b111100, 8'd0}) begin
      n_bad++;
      $display("FAIL b_first_run_cycle: got %b/%0d/%0d want 111100/0/0",
               {running_b, frame_start_b, line_start_b, de_b, hsync_b, vsync_b}, x_b, y_b);
    end
    for (int c = 0; c < 165; c++) begin
      int h, v;
      h = c % 15;
      v = c / 15;
      if (frame_start_b === 1'b1 && c != 0) fs_extra++;
      if (de_b === 1'b1) begin
        de_cnt++;
        if (x_b !== 4'(h) || y_b !== 4'(v)) x_err++;
      end
      if (vsync_b === 1'b1) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = c;
        vs_last = c;
      end
      if (hsync_b === 1'b1) begin
        hs_cnt++;
        if (h < 10 || h > 12) hs_bad++;
      end
      if (line_start_b === 1'b1) begin
        ls_cnt++;
        if (v >= 6) ls_late++;
      end
      tick(1);
    end
    n_cmp++;
    if (de_cnt !== 48) begin n_bad++; $display("FAIL de_per_frame: got %0d want 48", de_cnt); end
    n_cmp++;
    if (x_err !== 0) begin n_bad++; $display("FAIL xy_in_frame: got %0d errors want 0", x_err); end
    n_cmp++;
    if (vs_cnt !== 30 || vs_first !== 120 || vs_last !== 149) begin
      n_bad++;
      $display("FAIL vsync_window: got %0d cycles %0d..%0d want 30 cycles 120..149", vs_cnt, vs_first, vs_last);
    end
    n_cmp++;
    if (hs_cnt !== 33 || hs_bad !== 0) begin
      n_bad++;
      $display("FAIL hsync_active_high: got %0d cycles %0d outside want 33 cycles 0 outside", hs_cnt, hs_bad);
    end
    n_cmp++;
    if (ls_cnt !== 6 || ls_late !== 0) begin
      n_bad++;
      $display("FAIL line_start_frame: got %0d pulses %0d in blanking want 6 and 0", ls_cnt, ls_late);
    end
    n_cmp++;
    if (fs_extra !== 0 || frame_start_b !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_period: got extra=%0d fs_at_165=%b want 0 and 1", fs_extra, frame_start_b);
    end
  endtask

  task automatic test_lock_loss();
    tick(50);
    n_cmp++;
    if ({de_b, x_b, y_b} !== {1'b1, 4'd5, 4'd3}) begin
      n_bad++;
      $display("FAIL pre_loss_pos: got %b/%0d/%0d want 1/5/3", de_b, x_b, y_b);
    end
    lock_b = 1'b0;
    tick(2);
    n_cmp++;
    if (running_b !== 1'b1) begin n_bad++; $display("FAIL loss_sync_delay: got %b want 1", running_b); end
    tick(1);
    n_cmp++;
    if ({running_b, de_b, hsync_b, vsync_b, line_start_b, frame_start_b, x_b, y_b} !== 14'd0) begin
      n_bad++;
      $display("FAIL loss_idle: got %b/%0d/%0d want 000000/0/0",
               {running_b, de_b, hsync_b, vsync_b, line_start_b, frame_start_b}, x_b, y_b);
    end
    tick(4);
    n_cmp++;
    if (running_b !== 1'b0) begin n_bad++; $display("FAIL loss_hold: got %b want 0", running_b); end
    lock_b = 1'b1;
    tick(2);
    n_cmp++;
    if (running_b !== 1'b0) begin n_bad++; $display("FAIL relock_early: got %b want 0", running_b); end
    tick(1);
    n_cmp++;
    if ({running_b, frame_start_b, x_b, y_b} !== {2'b11, 8'd0}) begin
      n_bad++;
      $display("FAIL relock_origin: got %b/%0d/%0d want 11/0/0", {running_b, frame_start_b}, x_b, y_b);
    end
  endtask

  task automatic test_reset_mid_frame();
    tick(120);
    n_cmp++;
    if ({running_b, vsync_b, de_b, line_start_b} !== 4'b1100) begin
      n_bad++;
      $display("FAIL vsync_line_490_equiv: got %b want 1100", {running_b, vsync_b, de_b, line_start_b});
    end
    rst_b = 1'b1;
    tick(1);
    n_cmp++;
    if ({running_b, vsync_b, hsync_b, de_b} !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_reset: got %b want 0000", {running_b, vsync_b, hsync_b, de_b});
    end
    tick(2);
    n_cmp++;
    if (running_b !== 1'b0) begin n_bad++; $display("FAIL reset_overrides_lock: got %b want 0", running_b); end
    rst_b = 1'b0;
    tick(2);
    n_cmp++;
    if (running_b !== 1'b0) begin n_bad++; $display("FAIL post_reset_early: got %b want 0", running_b); end
    tick(1);
    n_cmp++;
    if ({running_b, frame_start_b} !== 2'b11) begin
      n_bad++;
      $display("FAIL post_reset_start: got %b want 11", {running_b, frame_start_b});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within 1 ms");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_power_up();
    test_line_timing();
    test_lock_glitch();
    test_frame_timing();
    test_lock_loss();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
